// File: rtl/eh2_lsu_trigger_ctl_pkg.sv
// Shared types and helpers for the LSU trigger-hit sequencer.
package eh2_lsu_trigger_ctl_pkg;

  localparam int unsigned NumTrig = 4;

  // One reported trigger hit: owning thread plus the trigger bits that fired.
  typedef struct packed {
    logic               tid;
    logic [NumTrig-1:0] vec;
  } eh2_lsu_trig_hit_pkt_t;

  typedef enum logic {
    StSlotEmpty,
    StSlotFull
  } slot_state_e;

  // Chained pairs report only when both halves match in the same cycle.
  function automatic logic [NumTrig-1:0] chain_qual(input logic [NumTrig-1:0] match,
                                                    input logic [1:0]         chain);
    logic [NumTrig-1:0] q;
    q = match;
    for (int unsigned p = 0; p < 2; p++) begin
      if (chain[p] && (match[2*p +: 2] != 2'b11)) begin
        q[2*p +: 2] = 2'b00;
      end
    end
    return q;
  endfunction

endpackage

// File: rtl/eh2_lsu_trig_slot.sv
// Single-thread pending trigger-hit slot: capture, merge, hand-off and flush.
module eh2_lsu_trig_slot
  import eh2_lsu_trigger_ctl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_l,
  input  logic         capture,
  input  logic [3:0]   qvec,
  input  logic         grant,
  input  logic         flush,
  output logic         full,
  output logic [3:0]   vec,
  output logic         merge
);

  slot_state_e state_q;
  logic [3:0]  vec_q;
  logic        merge_q;

  // Slot FSM; flush wins over everything, grant hands the old contents to the output.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StSlotEmpty;
      vec_q   <= '0;
      merge_q <= 1'b0;
    end else if (flush) begin
      state_q <= StSlotEmpty;
      vec_q   <= '0;
      merge_q <= 1'b0;
    end else begin
      unique case (state_q)
        StSlotEmpty: begin
          if (capture) begin
            state_q <= StSlotFull;
            vec_q   <= qvec;
          end
        end
        StSlotFull: begin
          if (grant) begin
            merge_q <= 1'b0;
            if (capture) begin
              // Old vec leaves this cycle; the new hit starts a fresh entry.
              vec_q <= qvec;
            end else begin
              state_q <= StSlotEmpty;
              vec_q   <= '0;
            end
          end else if (capture) begin
            vec_q   <= vec_q | qvec;
            merge_q <= 1'b1;
          end
        end
        default: state_q <= StSlotEmpty;
      endcase
    end
  end

  assign full  = (state_q == StSlotFull);
  assign vec   = vec_q;
  assign merge = merge_q;

endmodule

// File: rtl/eh2_lsu_trigger_ctl.sv
// LSU debug-trigger hit sequencer: chain qualification, per-thread slots,
// round-robin arbitration and a registered valid/ready output stage.
module eh2_lsu_trigger_ctl
  import eh2_lsu_trigger_ctl_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 2
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic [3:0]                  lsu_trigger_match_dc4,
  input  logic                        lsu_trig_tid_dc4,
  input  logic [NUM_THREADS-1:0][1:0] trig_chain,
  input  logic [NUM_THREADS-1:0]      dec_tlu_flush_lower_wb,
  input  logic                        lsu_trig_hit_ready,
  output logic                        lsu_trig_hit_valid,
  output logic                        lsu_trig_hit_tid,
  output logic [3:0]                  lsu_trig_hit_vec,
  output logic [NUM_THREADS-1:0]      lsu_trig_pend,
  output logic [NUM_THREADS-1:0]      lsu_trig_merge
);

  logic                        tid_eff;
  logic [1:0]                  chain_sel;
  logic [3:0]                  qvec;
  logic                        capture_any;
  logic [NUM_THREADS-1:0]      capture;
  logic [NUM_THREADS-1:0]      slot_full;
  logic [NUM_THREADS-1:0]      slot_merge;
  logic [NUM_THREADS-1:0][3:0] slot_vec;
  logic [NUM_THREADS-1:0]      eligible;
  logic [NUM_THREADS-1:0]      grant;
  logic                        grant_any;
  logic                        grant_tid;
  logic                        load_en;
  logic                        out_flush;
  logic [3:0]                  sel_vec;

  logic                        out_valid_q;
  eh2_lsu_trig_hit_pkt_t       out_pkt_q;

  if (NUM_THREADS == 2) begin : g_mt
    logic rr_ptr_q;

    assign tid_eff   = lsu_trig_tid_dc4;
    assign chain_sel = trig_chain[tid_eff];
    assign out_flush = out_valid_q & dec_tlu_flush_lower_wb[out_pkt_q.tid];

    // Single requester wins outright; contention is settled by the pointer.
    always_comb begin
      grant = '0;
      if (load_en) begin
        if (eligible == 2'b11) begin
          grant = rr_ptr_q ? 2'b10 : 2'b01;
        end else begin
          grant = eligible;
        end
      end
    end

    assign grant_tid = grant[1];

    // Pointer moves to the thread not just granted so contended grants alternate.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        rr_ptr_q <= 1'b0;
      end else if (grant_any) begin
        rr_ptr_q <= ~grant_tid;
      end
    end
  end else begin : g_st
    assign tid_eff   = 1'b0;
    assign chain_sel = trig_chain[0];
    assign out_flush = out_valid_q & dec_tlu_flush_lower_wb[0];
    assign grant     = load_en & eligible;
    assign grant_tid = 1'b0;
  end

  assign qvec        = chain_qual(lsu_trigger_match_dc4, chain_sel);
  assign capture_any = |qvec;
  // A slot being flushed this cycle must not reach the output.
  assign eligible    = slot_full & ~dec_tlu_flush_lower_wb;
  assign load_en     = ~out_valid_q | lsu_trig_hit_ready;
  assign grant_any   = |grant;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_slot
    assign capture[t] = capture_any & (tid_eff == 1'(t));

    eh2_lsu_trig_slot u_slot (
      .clk     (clk),
      .rst_l   (rst_l),
      .capture (capture[t]),
      .qvec    (qvec),
      .grant   (grant[t]),
      .flush   (dec_tlu_flush_lower_wb[t]),
      .full    (slot_full[t]),
      .vec     (slot_vec[t]),
      .merge   (slot_merge[t])
    );

    assign lsu_trig_pend[t] = slot_full[t] | (out_valid_q & (out_pkt_q.tid == 1'(t)));
  end

  // Grant is one-hot, so OR-ing the masked slot vectors selects the winner.
  always_comb begin
    sel_vec = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (grant[t]) begin
        sel_vec = sel_vec | slot_vec[t];
      end
    end
  end

  // Output register: reload on free/accepted, otherwise hold unless the held thread flushes.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else if (load_en) begin
      out_valid_q <= grant_any;
      if (grant_any) begin
        out_pkt_q.tid <= grant_tid;
        out_pkt_q.vec <= sel_vec;
      end
    end else if (out_flush) begin
      out_valid_q <= 1'b0;
    end
  end

  assign lsu_trig_hit_valid = out_valid_q;
  assign lsu_trig_hit_tid   = out_pkt_q.tid;
  assign lsu_trig_hit_vec   = out_pkt_q.vec;
  assign lsu_trig_merge     = slot_merge;

endmodule

// File: tb/tb_eh2_lsu_trigger_ctl.sv
// Randomised + directed bench for eh2_lsu_trigger_ctl with a queue scoreboard.
module tb_eh2_lsu_trigger_ctl;

  logic            clk;
  logic            rst_l;
  logic [3:0]      match;
  logic            tid;
  logic [1:0][1:0] chain;
  logic [1:0]      flush;
  logic            ready;
  logic            hit_valid;
  logic            hit_tid;
  logic [3:0]      hit_vec;
  logic [1:0]      pend;
  logic [1:0]      merge;

  int errors = 0;
  int checks = 0;

  eh2_lsu_trigger_ctl #(.NUM_THREADS(2)) dut (
    .clk                    (clk),
    .rst_l                  (rst_l),
    .lsu_trigger_match_dc4  (match),
    .lsu_trig_tid_dc4       (tid),
    .trig_chain             (chain),
    .dec_tlu_flush_lower_wb (flush),
    .lsu_trig_hit_ready     (ready),
    .lsu_trig_hit_valid     (hit_valid),
    .lsu_trig_hit_tid       (hit_tid),
    .lsu_trig_hit_vec       (hit_vec),
    .lsu_trig_pend          (pend),
    .lsu_trig_merge         (merge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queue/array level) ----------------
  bit         m_has[2];
  logic [3:0] m_vec[2];
  bit         m_mrg[2];
  bit         o_has;
  int         o_tid;
  logic [3:0] o_vec;
  int         next_pref;        // thread favoured when both wait
  logic [4:0] exp_q[$];         // {tid, vec} of hits expected on the port

  function automatic logic [3:0] qualify(input logic [3:0] m, input logic [1:0] ch);
    int v;
    int res = 0;
    for (int p = 0; p < 2; p++) begin
      int pair = (int'(m) >> (2 * p)) & 3;
      if (ch[p] && pair != 3) pair = 0;
      res = res + (pair << (2 * p));
    end
    return 4'(res);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      m_has[t] = 0;
      m_vec[t] = '0;
      m_mrg[t] = 0;
    end
    o_has     = 0;
    o_tid     = 0;
    o_vec     = '0;
    next_pref = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [3:0] q;
    int         ct;
    int         g;
    int         ncand;
    bit         can_load;
    q        = qualify(match, chain[tid]);
    ct       = (q != 0) ? int'(tid) : -1;
    can_load = !o_has || ready;
    g        = -1;
    ncand    = 0;
    for (int t = 0; t < 2; t++) if (m_has[t] && !flush[t]) ncand++;
    if (can_load && ncand == 2) g = next_pref;
    else if (can_load && ncand == 1) g = (m_has[0] && !flush[0]) ? 0 : 1;
    // output stage
    if (g >= 0) begin
      o_has = 1;
      o_tid = g;
      o_vec = m_vec[g];
      exp_q.push_back({1'(g), m_vec[g]});
      next_pref = 1 - g;
    end else if (can_load) begin
      o_has = 0;
    end else if (o_has && flush[o_tid]) begin
      o_has = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    // slots
    for (int t = 0; t < 2; t++) begin
      if (flush[t]) begin
        m_has[t] = 0;
        m_mrg[t] = 0;
      end else if (g == t) begin
        m_mrg[t] = 0;
        if (ct == t) m_vec[t] = q;
        else m_has[t] = 0;
      end else if (ct == t) begin
        if (m_has[t]) begin
          m_vec[t] = m_vec[t] | q;
          m_mrg[t] = 1;
        end else begin
          m_has[t] = 1;
          m_vec[t] = q;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_l) begin
      logic [4:0] e;
      chk("valid", hit_valid, o_has);
      for (int t = 0; t < 2; t++) begin
        chk($sformatf("pend%0d", t), pend[t], m_has[t] || (o_has && o_tid == t));
        chk($sformatf("merge%0d", t), merge[t], m_mrg[t]);
      end
      if (hit_valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_hit", {hit_tid, hit_vec}, 5'h1f);
          errors += ({hit_tid, hit_vec} == 5'h1f) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          chk("hit_pkt", {27'd0, hit_tid, hit_vec}, {27'd0, e});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] m, input logic t, input logic [3:0] ch,
                      input logic [1:0] fl, input logic rdy);
    match = m;
    tid   = t;
    chain = ch;
    flush = fl;
    ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 4'b0000, 2'b00, rdy);
  endtask

  task automatic latency_check(input string tag);
    step(4'b0001, 1'b0, 4'b0000, 2'b00, 1'b1);
    chk({tag, "_n1_valid"}, hit_valid, 0);
    idle(1'b1, 1);
    chk({tag, "_n2_valid"}, hit_valid, 1);
    chk({tag, "_n2_vec"}, hit_vec, 4'b0001);
    chk({tag, "_n2_tid"}, hit_tid, 0);
    idle(1'b1, 1);
    chk({tag, "_n3_valid"}, hit_valid, 0);
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  m;
    match = '0;
    tid   = 1'b0;
    chain = '0;
    flush = '0;
    ready = 1'b0;
    rst_l = 1'b0;
    #1;
    chk("rst_valid", hit_valid, 0);
    chk("rst_pend", pend, 0);
    chk("rst_merge", merge, 0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    idle(1'b1, 2);

    // basic latency and pass-through
    latency_check("lat");
    idle(1'b1, 2);

    // chain on pair 0 of thread 0
    step(4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1);
    idle(1'b1, 3);
    chk("chain_block_pend", pend, 0);
    step(4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1);
    idle(1'b1, 1);
    chk("chain_pass_vec", hit_vec, 4'b0011);
    idle(1'b1, 3);

    // back-to-back with consumer stalled, then merge
    step(4'b0001, 1'b0, 4'b0000, 2'b00, 1'b0);
    step(4'b0100, 1'b0, 4'b0000, 2'b00, 1'b0);
    chk("b2b_out_vec", hit_vec, 4'b0001);
    chk("b2b_merge", merge[0], 0);
    step(4'b1000, 1'b0, 4'b0000, 2'b00, 1'b0);
    chk("merge_set", merge[0], 1);
    idle(1'b1, 4);

    // both slots full, output stalled, then release
    step(4'b0001, 1'b0, 4'b0000, 2'b00, 1'b0);
    step(4'b0010, 1'b1, 4'b0000, 2'b00, 1'b0);
    step(4'b0100, 1'b0, 4'b0000, 2'b00, 1'b0);
    chk("both_full_pend", pend, 2'b11);
    idle(1'b1, 5);

    // T1 slot full, flush[1] with a simultaneous T1 capture
    step(4'b0001, 1'b0, 4'b0000, 2'b00, 1'b0);
    step(4'b0010, 1'b1, 4'b0000, 2'b00, 1'b0);
    step(4'b0100, 1'b1, 4'b0000, 2'b10, 1'b0);
    chk("flush_slot1_pend", pend[1], 0);
    // flush the held output thread while stalled
    step(4'b0000, 1'b0, 4'b0000, 2'b01, 1'b0);
    chk("flush_out_valid", hit_valid, 0);
    idle(1'b1, 3);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      m = r[3:0];
      if (r[23:21] == 3'd0) m = 4'b0000;
      step(m, r[4], (r[7:5] == 3'd0) ? r[11:8] : 4'b0000,
           (r[15:12] == 4'd0) ? r[17:16] : 2'b00, r[20:18] != 3'd0);
    end
    idle(1'b1, 6);

    // asynchronous reset while valid is high
    step(4'b0001, 1'b0, 4'b0000, 2'b00, 1'b0);
    step(4'b0010, 1'b1, 4'b0000, 2'b00, 1'b0);
    chk("pre_reset_valid", hit_valid, 1);
    #3 rst_l = 1'b0;
    #1;
    chk("arst_valid", hit_valid, 0);
    chk("arst_tid", hit_tid, 0);
    chk("arst_vec", hit_vec, 0);
    chk("arst_pend", pend, 0);
    chk("arst_merge", merge, 0);
    @(posedge clk);
    #1 rst_l = 1'b1;
    idle(1'b1, 1);
    latency_check("lat_after_rst");
    idle(1'b1, 4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
